mdu_sequencer: RTL and testbench

Multi-cycle sequencer for the RV32M multiply/divide unit in the EX stage. It accepts one M-extension operation from the pipeline, runs a 2-stage registered multiply or a 32-iteration restoring divide, and stalls IF/ID/EX until the result is ready. It resolves the RISC-V divide special cases without iterating and supports a pipeline flush abort.

---
 rtl/mdu_pkg.sv | 31 +++
 rtl/mdu_div_core.sv | 56 +++++
 rtl/mdu_sequencer.sv | 150 +++++++++++++++
 tb/tb_mdu_sequencer.sv | 132 +++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: op codes, FSM states and latencies.
package mdu_pkg;
    localparam int DATA_W    = 32;
    localparam int DIV_STEPS = 32;
    localparam int MUL_LAT   = 2;
    localparam int CNT_W     = $clog2(DIV_STEPS);

    localparam logic [4:0] ALU_MUL    = 5'b01000;
    localparam logic [4:0] ALU_MULH   = 5'b01001;
    localparam logic [4:0] ALU_MULHU  = 5'b01010;
    localparam logic [4:0] ALU_MULHSU = 5'b01011;
    localparam logic [4:0] ALU_DIV    = 5'b01100;
    localparam logic [4:0] ALU_DIVU   = 5'b01101;
    localparam logic [4:0] ALU_REM    = 5'b01110;
    localparam logic [4:0] ALU_REMU   = 5'b01111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } mdu_state_e;

    function automatic logic is_m_op(input logic [4:0] code);
        return (code >= ALU_MUL) && (code <= ALU_REMU);
    endfunction

    function automatic logic is_div_op(input logic [4:0] code);
        return (code >= ALU_DIV) && (code <= ALU_REMU);
    endfunction
endpackage

// File: rtl/mdu_div_core.sv
// Unsigned restoring divider: one quotient bit per step, operands are magnitudes.
module mdu_div_core
    import mdu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              last,
    output logic [DATA_W-1:0] quo_next,
    output logic [DATA_W-1:0] rem_next
);
    logic [DATA_W-1:0] quo;
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] dsr;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W:0]   rem_shift;
    logic [DATA_W:0]   diff;

    // quo doubles as the dividend shift register; its MSB feeds the partial remainder
    always_comb begin
        rem_shift = {rem, quo[DATA_W-1]};
        diff      = rem_shift - {1'b0, dsr};
        if (diff[DATA_W]) begin
            rem_next = rem_shift[DATA_W-1:0];
            quo_next = {quo[DATA_W-2:0], 1'b0};
        end else begin
            rem_next = diff[DATA_W-1:0];
            quo_next = {quo[DATA_W-2:0], 1'b1};
        end
    end

    assign last = step && (cnt == CNT_W'(DIV_STEPS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            quo <= '0;
            rem <= '0;
            dsr <= '0;
            cnt <= '0;
        end else if (load) begin
            quo <= dividend;
            rem <= '0;
            dsr <= divisor;
            cnt <= '0;
        end else if (step) begin
            quo <= quo_next;
            rem <= rem_next;
            cnt <= cnt + CNT_W'(1);
        end else begin
            cnt <= '0;
        end
    end
endmodule

// File: rtl/mdu_sequencer.sv
// EX-stage RV32M sequencer: 2-stage multiply, 32-step restoring divide, pipeline stall and flush.
module mdu_sequencer
    import mdu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [4:0]        alu_control,
    input  logic [DATA_W-1:0] data1,
    input  logic [DATA_W-1:0] data2,
    input  logic              flush,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    output logic              stall,
    output logic              busy
);
    mdu_state_e state, state_next;

    logic [1:0]                op_q;
    logic [DATA_W-1:0]         a_q, b_q;
    logic signed [DATA_W:0]    a_p0, b_p0;
    logic signed [2*DATA_W-1:0] prod_p0;
    logic                      mul_cnt, mul_done;
    logic                      neg_q, neg_r, rv_q;
    logic                      accept, div_load, div_step, div_last;
    logic                      in_is_div, in_signed, in_div0, in_ovf;
    logic [DATA_W-1:0]         a_mag, b_mag, div_quo, div_rem, special_res, result_d;

    function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v, input logic neg);
        return neg ? (~v + DATA_W'(1)) : v;
    endfunction

    function automatic logic signed [DATA_W:0] ext33(input logic [DATA_W-1:0] v, input logic sgn);
        return {sgn & v[DATA_W-1], v};
    endfunction

    assign in_is_div = is_div_op(alu_control);
    assign in_signed = ~alu_control[0];
    assign in_div0   = (data2 == '0);
    assign in_ovf    = in_signed && (data1 == 32'h8000_0000) && (data2 == '1);
    assign a_mag     = cond_neg(data1, in_signed & data1[DATA_W-1]);
    assign b_mag     = cond_neg(data2, in_signed & data2[DATA_W-1]);

    always_comb begin
        if (alu_control[1]) special_res = in_div0 ? data1 : '0;
        else                special_res = in_div0 ? '1 : 32'h8000_0000;
    end

    assign prod_p0  = 64'(a_p0) * 64'(b_p0);
    assign mul_done = (mul_cnt == 1'(MUL_LAT - 1));

    mdu_div_core u_div (
        .clk      (clk),
        .reset    (reset),
        .load     (div_load),
        .step     (div_step),
        .dividend (a_mag),
        .divisor  (b_mag),
        .last     (div_last),
        .quo_next (div_quo),
        .rem_next (div_rem)
    );

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        div_load   = 1'b0;
        div_step   = 1'b0;
        stall      = 1'b0;
        result_d   = result;
        unique case (state)
            ST_IDLE: begin
                if (start && is_m_op(alu_control) && !flush && !reset) begin
                    accept = 1'b1;
                    stall  = 1'b1;
                    if (!in_is_div) begin
                        state_next = ST_MUL;
                    end else if (in_div0 || in_ovf) begin
                        state_next = ST_DONE;
                        result_d   = special_res;
                    end else begin
                        state_next = ST_DIV;
                        div_load   = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                stall = 1'b1;
                if (flush) begin
                    state_next = ST_IDLE;
                end else if (mul_done) begin
                    state_next = ST_DONE;
                    result_d   = (op_q == 2'b00) ? prod_p0[DATA_W-1:0] : prod_p0[2*DATA_W-1:DATA_W];
                end
            end
            ST_DIV: begin
                stall    = 1'b1;
                div_step = !flush;
                if (flush) begin
                    state_next = ST_IDLE;
                end else if (div_last) begin
                    state_next = ST_DONE;
                    result_d   = op_q[1] ? cond_neg(div_rem, neg_r) : cond_neg(div_quo, neg_q);
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            a_p0    <= '0;
            b_p0    <= '0;
            mul_cnt <= 1'b0;
            result  <= '0;
            rv_q    <= 1'b0;
        end else begin
            if (accept) begin
                op_q  <= alu_control[1:0];
                a_q   <= data1;
                b_q   <= data2;
                neg_q <= in_signed & (data1[DATA_W-1] ^ data2[DATA_W-1]);
                neg_r <= in_signed & data1[DATA_W-1];
            end
            // multiply stage 1: sign/zero-extended operands; stage 2 lands in result
            if (state == ST_MUL && mul_cnt == 1'b0) begin
                a_p0 <= ext33(a_q, op_q != 2'b10);
                b_p0 <= ext33(b_q, !op_q[1]);
            end
            mul_cnt <= (state == ST_MUL) && !mul_done && !flush;
            result  <= result_d;
            rv_q    <= (state_next == ST_DONE);
        end
    end

    // a flush arriving in DONE still has to swallow the completion pulse
    assign result_valid = rv_q & ~flush;
    assign busy         = (state != ST_IDLE);
endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer: latencies, signed/unsigned results, special divides, flush and reset.
module tb_mdu_sequencer;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset, start, flush;
    logic [4:0]  alu_control;
    logic [31:0] data1, data2, result;
    logic        result_valid, stall, busy;
    int          n_assert = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    mdu_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .alu_control  (alu_control),
        .data1        (data1),
        .data2        (data2),
        .flush        (flush),
        .result       (result),
        .result_valid (result_valid),
        .stall        (stall),
        .busy         (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Presents an op at T0 and expects the completion pulse exactly at T<lat>.
    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int lat, input logic [31:0] exp);
        logic stall_ok, early;
        alu_control = op;
        data1       = a;
        data2       = b;
        start       = 1'b1;
        #1;
        stall_ok = stall;
        early    = 1'b0;
        for (int t = 1; t < lat; t++) begin
            tick();
            stall_ok &= stall;
            early    |= result_valid;
        end
        check({tag, " stall before done"}, 32'(stall_ok), 32'd1);
        check({tag, " early valid"}, 32'(early), 32'd0);
        tick();
        check({tag, " valid"}, 32'(result_valid), 32'd1);
        check({tag, " result"}, result, exp);
        check({tag, " stall in done"}, 32'(stall), 32'd0);
        tick();
        check({tag, " idle after done"}, {30'd0, busy, result_valid}, 32'd0);
        check({tag, " result held"}, result, exp);
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; flush = 1'b0;
        alu_control = 5'd0; data1 = '0; data2 = '0;
        tick();
        tick();
        check("reset result", result, 32'd0);
        check("reset flags", {29'd0, result_valid, stall, busy}, 32'd0);
        reset = 1'b0;
        tick();

        run_op("mul 7x-3",     ALU_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 3,  32'hFFFF_FFEB);
        run_op("mulhu",        ALU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 3,  32'hFFFF_FFFE);
        run_op("mulhsu",       ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3,  32'hFFFF_FFFF);
        run_op("mulh min",     ALU_MULH,   32'h8000_0000, 32'h8000_0000, 3,  32'h4000_0000);
        run_op("div -7/2",     ALU_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 33, 32'hFFFF_FFFD);
        run_op("rem -7/2",     ALU_REM,    32'hFFFF_FFF9, 32'h0000_0002, 33, 32'hFFFF_FFFF);
        run_op("div by 0",     ALU_DIV,    32'h1234_5678, 32'h0000_0000, 1,  32'hFFFF_FFFF);
        run_op("rem by 0",     ALU_REM,    32'h1234_5678, 32'h0000_0000, 1,  32'h1234_5678);
        run_op("div ovf",      ALU_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 1,  32'h8000_0000);
        run_op("rem ovf",      ALU_REM,    32'h8000_0000, 32'hFFFF_FFFF, 1,  32'h0000_0000);
        run_op("divu 100/7",   ALU_DIVU,   32'd100,       32'd7,         33, 32'd14);
        run_op("remu 100/7",   ALU_REMU,   32'd100,       32'd7,         33, 32'd2);

        // non-M op code must not be accepted
        alu_control = 5'b00000; data1 = 32'd1; data2 = 32'd2; start = 1'b1;
        #1;
        check("non-M stall", 32'(stall), 32'd0);
        tick();
        check("non-M busy", 32'(busy), 32'd0);
        start = 1'b0;

        // flush at T10 of a divide
        alu_control = ALU_DIVU; data1 = 32'd100; data2 = 32'd7; start = 1'b1;
        for (int t = 1; t <= 10; t++) tick();
        check("flush busy before", 32'(busy), 32'd1);
        flush = 1'b1;
        start = 1'b0;
        tick();
        flush = 1'b0;
        #1;
        check("flush idle", {29'd0, result_valid, stall, busy}, 32'd0);
        check("flush result untouched", result, 32'd2);
        run_op("mul after flush", ALU_MUL, 32'd3, 32'd5, 3, 32'd15);

        // reset asserted at T5 of a divide
        alu_control = ALU_DIVU; data1 = 32'h1234_5678; data2 = 32'd3; start = 1'b1;
        for (int t = 1; t <= 5; t++) tick();
        reset = 1'b1;
        #1;
        check("mid reset result", result, 32'd0);
        check("mid reset flags", {29'd0, result_valid, stall, busy}, 32'd0);
        tick();
        reset = 1'b0;
        start = 1'b0;
        tick();
        check("post reset idle", 32'(busy), 32'd0);
        run_op("divu 9/3", ALU_DIVU, 32'd9, 32'd3, 33, 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
